execute_stage: RTL and testbench

Execute stage of the 5-stage RV32I pipeline. It sits between the decode-to-execute register and the memory stage.
- Resolves operand forwarding.
- Performs the ALU operation.
- Resolves branches and jumps.
- Registers all execute-to-memory signals that the memory stage consumes: RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM and ALU_ResultM.

---
 rtl/execute_stage.sv | 133 +++++++++++++
 tb/tb_execute_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : RV32I execute stage. Resolves operand forwarding, performs
//                the ALU operation, resolves branches/jumps and holds the
//                execute-to-memory pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteE,
    input  logic                  MemWriteE,
    input  logic                  ResultSrcE,
    input  logic                  ALUSrcE,
    input  logic                  BranchE,
    input  logic                  BranchTypeE,
    input  logic                  JumpE,
    input  logic [2:0]            ALUControlE,
    input  logic [XLEN-1:0]       RD1_E,
    input  logic [XLEN-1:0]       RD2_E,
    input  logic [XLEN-1:0]       Imm_ExtE,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic [XLEN-1:0]       PCE,
    input  logic [XLEN-1:0]       PCPlus4E,
    input  logic [XLEN-1:0]       ResultW,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic                  FlushM,
    output logic                  PCSrcE,
    output logic [XLEN-1:0]       PCTargetE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  ResultSrcM,
    output logic [REG_ADDR_W-1:0] RD_M,
    output logic [XLEN-1:0]       PCPlus4M,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [XLEN-1:0]       ALU_ResultM
);

    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_XOR = 3'b100;
    localparam logic [2:0] c_ALU_SLT = 3'b101;
    localparam logic [2:0] c_ALU_SLL = 3'b110;
    localparam logic [2:0] c_ALU_SRL = 3'b111;

    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result;
    logic            w_lt;
    logic            w_zero;

    // Operand forwarding; ALU_ResultM is the pre-edge register value, so a
    // back-to-back dependency sees the previous instruction's result.
    always_comb begin
        w_src_a = RD1_E;
        w_fwd_b = RD2_E;
        case (ForwardAE)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = ALU_ResultM;
            default: w_src_a = RD1_E;
        endcase
        case (ForwardBE)
            2'b01:   w_fwd_b = ResultW;
            2'b10:   w_fwd_b = ALU_ResultM;
            default: w_fwd_b = RD2_E;
        endcase
        w_src_b = ALUSrcE ? Imm_ExtE : w_fwd_b;
    end

    // ALU; add/sub wrap, shifts use only the low bits of operand B.
    always_comb begin
        w_lt         = ($signed(w_src_a) < $signed(w_src_b));
        w_alu_result = '0;
        case (ALUControlE)
            c_ALU_ADD: w_alu_result = w_src_a + w_src_b;
            c_ALU_SUB: w_alu_result = w_src_a - w_src_b;
            c_ALU_AND: w_alu_result = w_src_a & w_src_b;
            c_ALU_OR:  w_alu_result = w_src_a | w_src_b;
            c_ALU_XOR: w_alu_result = w_src_a ^ w_src_b;
            c_ALU_SLT: w_alu_result = {{(XLEN-1){1'b0}}, w_lt};
            c_ALU_SLL: w_alu_result = w_src_a << w_src_b[SHAMT_W-1:0];
            c_ALU_SRL: w_alu_result = w_src_a >> w_src_b[SHAMT_W-1:0];
            default:   w_alu_result = '0;
        endcase
        w_zero = (w_alu_result == '0);
    end

    // Branch/jump resolution; not gated by FlushM.
    always_comb begin
        PCTargetE = PCE + Imm_ExtE;
        PCSrcE    = JumpE | (BranchE & (BranchTypeE ? ~w_zero : w_zero));
    end

    // Execute-to-memory register; a flush loads a control bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            if (FlushM) begin
                RegWriteM  <= 1'b0;
                MemWriteM  <= 1'b0;
                ResultSrcM <= 1'b0;
                RD_M       <= '0;
            end else begin
                RegWriteM  <= RegWriteE;
                MemWriteM  <= MemWriteE;
                ResultSrcM <= ResultSrcE;
                RD_M       <= RD_E;
            end
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= w_fwd_b;
            ALU_ResultM <= w_alu_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Scoreboard testbench for execute_stage with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE;
    logic        BranchE, BranchTypeE, JumpE, FlushM;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    execute_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
        .JumpE(JumpE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_ExtE(Imm_ExtE), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .FlushM(FlushM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, mw, rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        bit          ck_wd;
        logic [31:0] wd;
        bit          ck_alu;
        logic [31:0] alu;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    endfunction

    function automatic exp_t mk(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                                input logic [31:0] pc4, input bit ck_wd, input logic [31:0] wd,
                                input bit ck_alu, input logic [31:0] alu);
        exp_t e;
        e.rw = rw; e.mw = mw; e.rs = rs; e.rd = rd; e.pc4 = pc4;
        e.ck_wd = ck_wd; e.wd = wd; e.ck_alu = ck_alu; e.alu = alu;
        return e;
    endfunction

    task automatic clear_inputs();
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0;
        BranchE = 0; BranchTypeE = 0; JumpE = 0; FlushM = 0;
        ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_ExtE = 0;
        PCE = 0; PCPlus4E = 0; ResultW = 0; RD_E = 0;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
    endtask

    // Inputs are already applied (after a negedge); optionally check the
    // combinational branch outputs, then queue the registered expectation.
    task automatic issue(input exp_t e, input bit ck_pc, input logic pcsrc, input logic [31:0] tgt);
        #1;
        if (ck_pc) begin
            chk("PCSrcE", {31'b0, PCSrcE}, {31'b0, pcsrc});
            chk("PCTargetE", PCTargetE, tgt);
        end
        q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " RegWriteM"},  {31'b0, RegWriteM}, 0);
        chk({tag, " MemWriteM"},  {31'b0, MemWriteM}, 0);
        chk({tag, " ResultSrcM"}, {31'b0, ResultSrcM}, 0);
        chk({tag, " RD_M"},       {27'b0, RD_M}, 0);
        chk({tag, " PCPlus4M"},   PCPlus4M, 0);
        chk({tag, " WriteDataM"}, WriteDataM, 0);
        chk({tag, " ALU_ResultM"}, ALU_ResultM, 0);
    endtask

    // Monitor: after every active edge, compare registered outputs against
    // the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("RegWriteM",  {31'b0, RegWriteM},  {31'b0, e.rw});
                chk("MemWriteM",  {31'b0, MemWriteM},  {31'b0, e.mw});
                chk("ResultSrcM", {31'b0, ResultSrcM}, {31'b0, e.rs});
                chk("RD_M",       {27'b0, RD_M},       {27'b0, e.rd});
                chk("PCPlus4M",   PCPlus4M, e.pc4);
                if (e.ck_wd)  chk("WriteDataM", WriteDataM, e.wd);
                if (e.ck_alu) chk("ALU_ResultM", ALU_ResultM, e.alu);
            end
        end
    end

    // Stimulus
    initial begin
        // Reset held with all inputs nonzero
        rst = 1'b0;
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; ALUSrcE = 1;
        BranchE = 1; BranchTypeE = 1; JumpE = 1; FlushM = 0;
        ALUControlE = 3'b011; RD1_E = 32'h1111_1111; RD2_E = 32'h2222_2222;
        Imm_ExtE = 32'h3333_3333; PCE = 32'h44; PCPlus4E = 32'h48;
        ResultW = 32'h5555_5555; RD_E = 5'd7; ForwardAE = 2'b01; ForwardBE = 2'b10;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");

        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        // add 5 + 7
        RD1_E = 5; RD2_E = 7;
        issue(mk(0, 0, 0, 0, 0, 1, 7, 1, 12), 0, 0, 0);

        // Seed ALU_ResultM = 0x10
        @(negedge clk); clear_inputs();
        RD1_E = 32'h10;
        issue(mk(0, 0, 0, 0, 0, 1, 0, 1, 32'h10), 0, 0, 0);

        // A from ALU_ResultM (pre-edge 0x10), B from ResultW
        @(negedge clk); clear_inputs();
        RD1_E = 1; RD2_E = 2; ResultW = 32'h20; ForwardAE = 2'b10; ForwardBE = 2'b01;
        issue(mk(0, 0, 0, 0, 0, 1, 32'h20, 1, 32'h30), 0, 0, 0);

        // ForwardAE=11 selects RD1_E
        @(negedge clk); clear_inputs();
        RD1_E = 1; RD2_E = 2; ResultW = 32'h20; ForwardAE = 2'b11;
        issue(mk(0, 0, 0, 0, 0, 1, 2, 1, 3), 0, 0, 0);

        // A from ResultW, B from ALU_ResultM (now 3)
        @(negedge clk); clear_inputs();
        RD1_E = 1; RD2_E = 2; ResultW = 32'h20; ForwardAE = 2'b01; ForwardBE = 2'b10;
        issue(mk(0, 0, 0, 0, 0, 1, 3, 1, 32'h23), 0, 0, 0);

        // beq taken, backwards target
        @(negedge clk); clear_inputs();
        BranchE = 1; RD1_E = 9; RD2_E = 9; ALUControlE = 3'b001;
        PCE = 32'h100; Imm_ExtE = 32'hFFFF_FFF8;
        issue(mk(0, 0, 0, 0, 0, 1, 9, 1, 0), 1, 1, 32'hF8);

        // bne with equal operands: not taken
        @(negedge clk); clear_inputs();
        BranchE = 1; BranchTypeE = 1; RD1_E = 9; RD2_E = 9; ALUControlE = 3'b001;
        PCE = 32'h100; Imm_ExtE = 32'hFFFF_FFF8;
        issue(mk(0, 0, 0, 0, 0, 1, 9, 1, 0), 1, 0, 32'hF8);

        // bne with unequal operands: taken
        @(negedge clk); clear_inputs();
        BranchE = 1; BranchTypeE = 1; RD1_E = 9; RD2_E = 8; ALUControlE = 3'b001;
        PCE = 32'h200; Imm_ExtE = 32'h10;
        issue(mk(0, 0, 0, 0, 0, 1, 8, 1, 1), 1, 1, 32'h210);

        // jal
        @(negedge clk); clear_inputs();
        JumpE = 1; RegWriteE = 1; RD_E = 1; PCE = 32'h200; PCPlus4E = 32'h204; Imm_ExtE = 32'h40;
        issue(mk(1, 0, 0, 1, 32'h204, 0, 0, 0, 0), 1, 1, 32'h240);

        // Flushed instruction becomes a bubble
        @(negedge clk); clear_inputs();
        MemWriteE = 1; RegWriteE = 1; ResultSrcE = 1; RD_E = 3; FlushM = 1;
        issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);

        // Store with immediate address: WriteDataM is RD2, not the immediate
        @(negedge clk); clear_inputs();
        MemWriteE = 1; ResultSrcE = 1; RD_E = 3; ALUSrcE = 1; Imm_ExtE = 3; RD1_E = 4; RD2_E = 32'h55;
        issue(mk(0, 1, 1, 3, 0, 1, 32'h55, 1, 7), 0, 0, 0);

        // ALU sweep with A=0x80000000, B=1
        @(negedge clk); clear_inputs();
        RD1_E = 32'h8000_0000; RD2_E = 1; ALUControlE = 3'b110;
        issue(mk(0, 0, 0, 0, 0, 1, 1, 1, 0), 0, 0, 0);
        @(negedge clk); clear_inputs();
        RD1_E = 32'h8000_0000; RD2_E = 1; ALUControlE = 3'b111;
        issue(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h4000_0000), 0, 0, 0);
        @(negedge clk); clear_inputs();
        RD1_E = 32'h8000_0000; RD2_E = 1; ALUControlE = 3'b101;
        issue(mk(0, 0, 0, 0, 0, 1, 1, 1, 1), 0, 0, 0);
        @(negedge clk); clear_inputs();
        RD1_E = 32'h8000_0000; RD2_E = 1; ALUControlE = 3'b100;
        issue(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h8000_0001), 0, 0, 0);
        @(negedge clk); clear_inputs();
        RD1_E = 32'h8000_0000; RD2_E = 1; ALUControlE = 3'b011;
        issue(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'h8000_0001), 0, 0, 0);
        @(negedge clk); clear_inputs();
        RD1_E = 32'hF0F0_1234; RD2_E = 32'h0FF0_00FF; ALUControlE = 3'b010;
        issue(mk(0, 0, 0, 0, 0, 1, 32'h0FF0_00FF, 1, 32'h00F0_0034), 0, 0, 0);
        // slt reversed: 1 < 0x80000000 is false when signed
        @(negedge clk); clear_inputs();
        RD1_E = 1; RD2_E = 32'h8000_0000; ALUControlE = 3'b101;
        issue(mk(0, 0, 0, 0, 0, 1, 32'h8000_0000, 1, 0), 0, 0, 0);
        // sll uses only the low 5 bits of B (0x21 -> shift by 1)
        @(negedge clk); clear_inputs();
        RD1_E = 1; RD2_E = 32'h21; ALUControlE = 3'b110;
        issue(mk(0, 0, 0, 0, 0, 1, 32'h21, 1, 2), 0, 0, 0);
        // sub 0 - 1 wraps
        @(negedge clk); clear_inputs();
        RD1_E = 0; RD2_E = 1; ALUControlE = 3'b001;
        issue(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'hFFFF_FFFF), 0, 0, 0);
        // add wraps
        @(negedge clk); clear_inputs();
        RD1_E = 32'hFFFF_FFFF; RD2_E = 2; RegWriteE = 1; RD_E = 5'd31; PCPlus4E = 32'hABC;
        issue(mk(1, 0, 0, 31, 32'hABC, 1, 2, 1, 1), 0, 0, 0);

        // Drain the scoreboard, bounded
        begin
            int waited = 0;
            while (q.size() > 0 && waited < 10) begin
                @(posedge clk);
                #2;
                waited++;
            end
            if (q.size() > 0) begin
                n_checks++;
                $display("FAIL drain: actual=%0d pending expected=0 pending", q.size());
            end
        end

        // Asynchronous reset mid-operation: outputs are nonzero now
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk);
        #1 check_all_zero("reset_hold");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
